// File: rtl/cpu.sv
// Small 8-bit multicycle CPU: FETCH/DECODE/EXECUTE, four GPRs, RH:RL pair for MUL/DIV.
// Define CPU_MULDIV_EN to build the multiplier/divider (opcodes 20/21); otherwise they are NOPs.
module cpu #(
  parameter int unsigned RAM_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RAM_SIZE*32-1:0] ram,
  output logic [7:0]            flags,
  output logic [7:0]            al,
  output logic [7:0]            bl,
  output logic [7:0]            cl,
  output logic [7:0]            dl,
  output logic [15:0]           r_l_h,
  output logic [31:0]           ir,
  output logic [15:0]           clks,
  output logic [7:0]            pc,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    StFetch   = 2'd0,
    StDecode  = 2'd1,
    StExecute = 2'd2,
    StHalt    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  gpr_q [4];
  logic [7:0]  opa_q, opb_q, pc_q;
  logic [31:0] ir_q;
  logic [15:0] clks_q, rlh_q, rlh_d;
  logic        z_q, c_q, s_q, v_q, dz_q, hlt_q;
  logic        z_d, c_d, s_d, v_d, dz_d;

  logic [7:0]  opcode, alu_res, wr_val;
  logic [1:0]  dst, src;
  logic        imm_form, wr_en, alu_op, jump, halt_op;
  logic [8:0]  sum9, diff9;
  logic [31:0] fetch_word;

  assign opcode   = ir_q[31:24];
  assign dst      = ir_q[23:22];
  assign src      = ir_q[21:20];
  assign imm_form = (opcode == 8'h02) || (opcode == 8'h04) || (opcode == 8'h06) ||
                    (opcode == 8'h0A);
  assign sum9     = {1'b0, opa_q} + {1'b0, opb_q};
  assign diff9    = {1'b0, opa_q} - {1'b0, opb_q};

  // Words past the end of program memory read as NOP.
  always_comb begin
    fetch_word = '0;
    for (int i = 0; i < int'(RAM_SIZE); i++) begin
      if (pc_q == 8'(i)) fetch_word = ram[i*32 +: 32];
    end
  end

`ifdef CPU_MULDIV_EN
  logic [15:0] prod;
  logic [7:0]  quot, rem;
  assign prod = {8'h00, opa_q} * {8'h00, opb_q};
  assign quot = (opb_q == 8'h00) ? 8'hFF : opa_q / opb_q;
  assign rem  = (opb_q == 8'h00) ? opa_q : opa_q % opb_q;
`endif

  always_comb begin
    wr_en   = 1'b0;
    wr_val  = opb_q;
    alu_op  = 1'b0;
    alu_res = 8'h00;
    jump    = 1'b0;
    halt_op = 1'b0;
    z_d     = z_q;
    c_d     = c_q;
    s_d     = s_q;
    v_d     = v_q;
    dz_d    = dz_q;
    rlh_d   = rlh_q;
    case (opcode)
      8'h01, 8'h02: wr_en = 1'b1;
      8'h03, 8'h04: begin
        alu_op  = 1'b1;
        wr_en   = 1'b1;
        alu_res = sum9[7:0];
        c_d     = sum9[8];
        v_d     = (opa_q[7] == opb_q[7]) && (alu_res[7] != opa_q[7]);
      end
      8'h05, 8'h06, 8'h0A: begin
        alu_op  = 1'b1;
        wr_en   = (opcode != 8'h0A);
        alu_res = diff9[7:0];
        c_d     = diff9[8];
        v_d     = (opa_q[7] != opb_q[7]) && (alu_res[7] != opa_q[7]);
      end
      8'h07, 8'h08, 8'h09: begin
        alu_op  = 1'b1;
        wr_en   = 1'b1;
        alu_res = (opcode == 8'h07) ? (opa_q & opb_q) :
                  (opcode == 8'h08) ? (opa_q | opb_q) : (opa_q ^ opb_q);
        c_d     = 1'b0;
        v_d     = 1'b0;
      end
      8'h10: jump = 1'b1;
      8'h11: jump = z_q;
      8'h12: jump = !z_q;
      8'h13: jump = c_q;
`ifdef CPU_MULDIV_EN
      8'h20: begin
        rlh_d = prod;
        z_d   = (prod == 16'h0000);
        c_d   = (prod[15:8] != 8'h00);
        s_d   = 1'b0;
        v_d   = 1'b0;
        dz_d  = 1'b0;
      end
      8'h21: begin
        rlh_d = {rem, quot};
        z_d   = (opb_q != 8'h00) && (quot == 8'h00);
        dz_d  = (opb_q == 8'h00);
        c_d   = 1'b0;
        s_d   = 1'b0;
        v_d   = 1'b0;
      end
`endif
      8'hFF: halt_op = 1'b1;
      default: ;
    endcase
    if (alu_op) begin
      wr_val = alu_res;
      z_d    = (alu_res == 8'h00);
      s_d    = alu_res[7];
      dz_d   = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:   state_d = StDecode;
      StDecode:  state_d = StExecute;
      StExecute: state_d = halt_op ? StHalt : StFetch;
      default:   state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      for (int i = 0; i < 4; i++) gpr_q[i] <= 8'h00;
      opa_q  <= 8'h00;
      opb_q  <= 8'h00;
      pc_q   <= 8'h00;
      ir_q   <= 32'h0;
      clks_q <= 16'h0;
      rlh_q  <= 16'h0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      s_q    <= 1'b0;
      v_q    <= 1'b0;
      dz_q   <= 1'b0;
      hlt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q != StHalt) clks_q <= clks_q + 16'd1;
      case (state_q)
        StFetch:  ir_q <= fetch_word;
        StDecode: begin
          opa_q <= gpr_q[dst];
          opb_q <= imm_form ? ir_q[7:0] : gpr_q[src];
        end
        StExecute: begin
          if (wr_en) gpr_q[dst] <= wr_val;
          z_q   <= z_d;
          c_q   <= c_d;
          s_q   <= s_d;
          v_q   <= v_d;
          dz_q  <= dz_d;
          rlh_q <= rlh_d;
          if (halt_op) hlt_q <= 1'b1;
          else         pc_q  <= jump ? ir_q[7:0] : pc_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign flags = {hlt_q, 2'b00, dz_q, v_q, s_q, c_q, z_q};
  assign al    = gpr_q[0];
  assign bl    = gpr_q[1];
  assign cl    = gpr_q[2];
  assign dl    = gpr_q[3];
  assign r_l_h = rlh_q;
  assign ir    = ir_q;
  assign clks  = clks_q;
  assign pc    = pc_q;
  assign state = state_q;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed scenarios plus random programs checked against an
// instruction-level interpreter.
module tb_cpu;
  localparam int unsigned RamSize = 16;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [RamSize*32-1:0]  ram = '0;
  logic [7:0]             flags, al, bl, cl, dl, pc;
  logic [15:0]            r_l_h, clks;
  logic [31:0]            ir;
  logic [1:0]             state;

  cpu #(.RAM_SIZE(RamSize)) dut (
    .clk(clk), .reset(reset), .ram(ram), .flags(flags), .al(al), .bl(bl), .cl(cl),
    .dl(dl), .r_l_h(r_l_h), .ir(ir), .clks(clks), .pc(pc), .state(state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] prog [RamSize];

  // Interpreter state
  int m_reg [4];
  int m_pc, m_rlh, m_clks;
  bit m_z, m_c, m_s, m_v, m_dz;

  task automatic clear_prog();
    for (int i = 0; i < int'(RamSize); i++) prog[i] = 32'h0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < int'(RamSize); i++) ram[i*32 +: 32] = prog[i];
  endtask

  task automatic advance(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_pc = 0; m_rlh = 0; m_clks = 0;
    m_z = 0; m_c = 0; m_s = 0; m_v = 0; m_dz = 0;
  endtask

  function automatic int sx(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic logic [7:0] m_flags();
    return {3'b000, m_dz, m_v, m_s, m_c, m_z};
  endfunction

  // Executes one instruction at the architectural level.
  task automatic model_exec();
    logic [31:0] w;
    int op, d, s, imm, a, b, r, t;
    bit jmp, alu;
    w   = (m_pc < int'(RamSize)) ? prog[m_pc] : 32'h0;
    op  = int'(w[31:24]);
    d   = int'(w[23:22]);
    s   = int'(w[21:20]);
    imm = int'(w[7:0]);
    a   = m_reg[d];
    b   = (op == 'h02 || op == 'h04 || op == 'h06 || op == 'h0A) ? imm : m_reg[s];
    jmp = 0; alu = 0; r = 0;
    case (op)
      'h01, 'h02: m_reg[d] = b;
      'h03, 'h04: begin
        t = a + b; r = t % 256; m_c = (t > 255);
        t = sx(a) + sx(b); m_v = (t > 127) || (t < -128); alu = 1;
      end
      'h05, 'h06, 'h0A: begin
        r = (a - b + 256) % 256; m_c = (a < b);
        t = sx(a) - sx(b); m_v = (t > 127) || (t < -128); alu = 1;
      end
      'h07: begin r = a & b; m_c = 0; m_v = 0; alu = 1; end
      'h08: begin r = a | b; m_c = 0; m_v = 0; alu = 1; end
      'h09: begin r = a ^ b; m_c = 0; m_v = 0; alu = 1; end
      'h10: jmp = 1;
      'h11: jmp = m_z;
      'h12: jmp = !m_z;
      'h13: jmp = m_c;
`ifdef CPU_MULDIV_EN
      'h20: begin
        m_rlh = a * b; m_z = (m_rlh == 0); m_c = (m_rlh > 255);
        m_s = 0; m_v = 0; m_dz = 0;
      end
      'h21: begin
        if (b == 0) begin m_rlh = a * 256 + 255; m_dz = 1; m_z = 0; end
        else begin m_rlh = (a % b) * 256 + a / b; m_dz = 0; m_z = (a / b == 0); end
        m_c = 0; m_s = 0; m_v = 0;
      end
`endif
      default: ;
    endcase
    if (alu) begin
      m_z = (r == 0); m_s = (r >= 128); m_dz = 0;
      if (op != 'h0A) m_reg[d] = r;
    end
    m_pc   = jmp ? imm : (m_pc + 1) % 256;
    m_clks = (m_clks + 3) % 65536;
  endtask

  task automatic test_reset();
    clear_prog(); load_prog();
    apply_reset();
    checks++;
    if ({flags, al, bl, cl, dl, r_l_h, ir, clks, pc, state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got flags=%h regs=%h%h%h%h rlh=%h ir=%h clks=%h pc=%h st=%h, want all 0",
               flags, al, bl, cl, dl, r_l_h, ir, clks, pc, state);
    end
  endtask

  task automatic test_move_jump();
    clear_prog();
    prog[0] = 32'h02000005; prog[1] = 32'h01400000; prog[2] = 32'h10000000;
    load_prog(); apply_reset();
    advance(6);
    checks++;
    if (al !== 8'h05 || bl !== 8'h05) begin
      errors++; $display("FAIL mov_regs: got al=%h bl=%h want 05 05", al, bl);
    end
    advance(3);
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL jmp_pc: got %h want 00", pc); end
    checks++;
    if (clks !== 16'd9) begin errors++; $display("FAIL jmp_clks: got %0d want 9", clks); end
    checks++;
    if (flags !== 8'h00) begin errors++; $display("FAIL mov_flags: got %h want 00", flags); end
  endtask

  task automatic test_add_sub();
    clear_prog();
    prog[0] = 32'h020000F0; prog[1] = 32'h04000020; prog[2] = 32'h06000010;
    load_prog(); apply_reset();
    advance(6);
    checks++;
    if (al !== 8'h10 || flags !== 8'h02) begin
      errors++; $display("FAIL add_carry: got al=%h flags=%h want 10 02", al, flags);
    end
    advance(3);
    checks++;
    if (al !== 8'h00 || flags !== 8'h01) begin
      errors++; $display("FAIL sub_zero: got al=%h flags=%h want 00 01", al, flags);
    end
  endtask

  task automatic test_cond_jump();
    logic [7:0] want_pc [2];
    want_pc = '{8'h07, 8'h03};
    for (int k = 0; k < 2; k++) begin
      clear_prog();
      prog[0] = 32'h02000000 | k; prog[1] = 32'h0A000000; prog[2] = 32'h11000007;
      load_prog(); apply_reset();
      advance(9);
      checks++;
      if (pc !== want_pc[k]) begin
        errors++; $display("FAIL jz_al%0d: got pc=%h want %h", k, pc, want_pc[k]);
      end
    end
  endtask

  task automatic test_muldiv();
    logic [15:0] want [4];
    logic        want_dz [4];
    logic [7:0]  got_f;
`ifdef CPU_MULDIV_EN
    want = '{16'h009C, 16'hFE01, 16'h020E, 16'h64FF};
    want_dz = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
    want = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    want_dz = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    clear_prog();
    prog[0]  = 32'h0200000C; prog[1] = 32'h0240000D; prog[2] = 32'h20100000;
    prog[3]  = 32'h020000FF; prog[4] = 32'h024000FF; prog[5] = 32'h20100000;
    prog[6]  = 32'h02000064; prog[7] = 32'h02400007; prog[8] = 32'h21100000;
    prog[9]  = 32'h02400000; prog[10] = 32'h21100000;
    load_prog(); apply_reset();
    for (int k = 0; k < 4; k++) begin
      advance(k == 3 ? 6 : 9);
      got_f = flags;
      checks++;
      if (r_l_h !== want[k] || got_f[4] !== want_dz[k]) begin
        errors++;
        $display("FAIL muldiv_%0d: got rlh=%h dz=%b want %h %b", k, r_l_h, got_f[4], want[k],
                 want_dz[k]);
      end
`ifdef CPU_MULDIV_EN
      if (k < 2) begin
        checks++;
        if (got_f[1] !== (k == 1)) begin
          errors++; $display("FAIL mul_carry_%0d: got C=%b want %b", k, got_f[1], k == 1);
        end
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [7:0] ops [20];
    logic [7:0] dreg [4];
    logic [7:0] op, imm;
    ops = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
            8'h0A, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h0B, 8'h7E, 8'h06};
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < int'(RamSize); i++) begin
        op  = ops[$urandom_range(0, 19)];
        imm = (op >= 8'h10 && op <= 8'h13) ? 8'($urandom_range(0, 19)) : 8'($urandom);
        prog[i] = {op, 2'($urandom), 2'($urandom), 12'h000, imm};
      end
      load_prog(); apply_reset();
      for (int n = 0; n < 30; n++) begin
        model_exec();
        advance(3);
        dreg = '{al, bl, cl, dl};
        for (int r = 0; r < 4; r++) begin
          checks++;
          if (dreg[r] !== 8'(m_reg[r])) begin
            errors++;
            $display("FAIL rand_reg%0d p%0d n%0d: got %h want %h", r, p, n, dreg[r],
                     8'(m_reg[r]));
          end
        end
        checks++;
        if (flags !== m_flags() || pc !== 8'(m_pc) || r_l_h !== 16'(m_rlh) ||
            clks !== 16'(m_clks) || state !== 2'd0) begin
          errors++;
          $display("FAIL rand_state p%0d n%0d: got f=%h pc=%h rlh=%h clks=%h st=%0d want f=%h pc=%h rlh=%h clks=%h st=0",
                   p, n, flags, pc, r_l_h, clks, state, m_flags(), 8'(m_pc), 16'(m_rlh),
                   16'(m_clks));
        end
      end
    end
  endtask

  task automatic test_halt();
    logic [7:0]  pc_h;
    logic [15:0] clks_h;
    clear_prog();
    prog[0] = 32'h02000003; prog[1] = 32'hFF000000; prog[2] = 32'h02000055;
    load_prog(); apply_reset();
    advance(6);
    checks++;
    if (state !== 2'd3 || flags[7] !== 1'b1) begin
      errors++; $display("FAIL hlt_enter: got state=%0d flags=%h want 3 and bit7", state, flags);
    end
    checks++;
    if (clks !== 16'd6) begin errors++; $display("FAIL hlt_clks: got %0d want 6", clks); end
    pc_h = pc; clks_h = clks;
    advance(20);
    checks++;
    if (pc !== pc_h || clks !== clks_h || al !== 8'h03 || ir !== 32'hFF000000) begin
      errors++;
      $display("FAIL hlt_frozen: got pc=%h clks=%0d al=%h ir=%h want pc=%h clks=%0d al=03 ir=ff000000",
               pc, clks, al, ir, pc_h, clks_h);
    end
    apply_reset();
    checks++;
    if ({flags, al, bl, cl, dl, r_l_h, ir, clks, pc, state} !== '0) begin
      errors++;
      $display("FAIL hlt_reset: got flags=%h al=%h ir=%h clks=%h pc=%h st=%0d want all 0",
               flags, al, ir, clks, pc, state);
    end
  endtask

  task automatic test_reset_mid();
    clear_prog();
    prog[0] = 32'h024000AA;
    load_prog(); apply_reset();
    advance(2);
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL mid_state: got %0d want 2", state); end
    apply_reset();
    checks++;
    if (bl !== 8'h00 || state !== 2'd0) begin
      errors++; $display("FAIL mid_abort: got bl=%h state=%0d want 00 0", bl, state);
    end
    advance(3);
    checks++;
    if (bl !== 8'hAA) begin errors++; $display("FAIL mid_rerun: got bl=%h want aa", bl); end
  endtask

  initial begin
    test_reset();
    test_move_jump();
    test_add_sub();
    test_cond_jump();
    test_muldiv();
    test_random();
    test_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
